// File: rtl/board_io_if.sv
// board_io_if: raw board pins in, conditioned levels, press pulses and sticky events out
interface board_io_if #(
  parameter int NUM_SW  = 18,
  parameter int NUM_BTN = 4
);
  logic [NUM_SW-1:0]  i_sw;
  logic [NUM_BTN-1:0] i_btn;
  logic [NUM_BTN-1:0] i_evt_clr;
  logic [31:0]        o_io_sw;
  logic [31:0]        o_io_btn;
  logic [NUM_BTN-1:0] o_btn_press;
  logic [NUM_BTN-1:0] o_btn_evt;
  modport master (
    output i_sw, i_btn, i_evt_clr,
    input  o_io_sw, o_io_btn, o_btn_press, o_btn_evt
  );
  modport slave (
    input  i_sw, i_btn, i_evt_clr,
    output o_io_sw, o_io_btn, o_btn_press, o_btn_evt
  );
endinterface

// File: rtl/board_io_conditioner.sv
// board_io_conditioner: sync, debounce and normalise board switches/keys; sticky press events built only with BOARD_IO_EVT_LATCH_EN
module board_io_conditioner #(
  parameter int NUM_SW          = 18,
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input logic       i_clk,
  input logic       i_rst_n,
  board_io_if.slave io
);
  localparam int W  = NUM_SW + NUM_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [W-1:0]       raw, sync1_q, sync2_q, stable_q, stable_d;
  logic [CW-1:0]      cnt_q [W];
  logic [CW-1:0]      cnt_d [W];
  logic [NUM_BTN-1:0] btn_lvl, prev_q, press_q, press_d, evt;
  // buttons are flipped to active-high before they ever reach a flop
  assign raw     = {io.i_btn ^ {NUM_BTN{BTN_ACTIVE_LOW}}, io.i_sw};
  assign btn_lvl = stable_q[W-1:NUM_SW];
  // per-channel counter: accept a new level only after an unbroken run of differing samples
  always_comb begin
    stable_d = stable_q;
    for (int c = 0; c < W; c++) begin
      cnt_d[c]    = (sync2_q[c] == stable_q[c] || cnt_q[c] == LAST) ? '0 : cnt_q[c] + 1'b1;
      stable_d[c] = (sync2_q[c] != stable_q[c] && cnt_q[c] == LAST) ? sync2_q[c] : stable_q[c];
    end
  end
  // rising edge of the debounced button level, registered one cycle later
  always_comb press_d = btn_lvl & ~prev_q;
  // synchronisers, debounce state and press pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
      prev_q   <= '0;
      press_q  <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= btn_lvl;
      press_q  <= press_d;
    end
  end
`ifdef BOARD_IO_EVT_LATCH_EN
  logic [NUM_BTN-1:0] evt_q, evt_d;
  // set wins over clear so a press coinciding with a software clear is never lost
  always_comb evt_d = press_d | (evt_q & ~io.i_evt_clr);
  // sticky event flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) evt_q <= '0;
    else evt_q <= evt_d;
  end
  assign evt = evt_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = ^io.i_evt_clr;
  assign evt            = '0;
`endif
  assign io.o_io_sw     = 32'(stable_q[NUM_SW-1:0]);
  assign io.o_io_btn    = {16'(evt), 16'(btn_lvl)};
  assign io.o_btn_press = press_q;
  assign io.o_btn_evt   = evt;
endmodule

// File: tb/tb_board_io_conditioner.sv
// tb_board_io_conditioner: directed scenarios plus random stimulus against a sample-history reference model
module tb_board_io_conditioner;
  localparam int NSW = 18, NBTN = 4, DC = 4, W = NSW + NBTN;
`ifdef BOARD_IO_EVT_LATCH_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  board_io_if #(.NUM_SW(NSW), .NUM_BTN(NBTN)) io();
  board_io_conditioner #(
    .NUM_SW(NSW), .NUM_BTN(NBTN), .DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .io(io)
  );
  logic [71:0] got;
  assign got = {io.o_io_sw, io.o_io_btn, io.o_btn_press, io.o_btn_evt};
  // reference: a level is accepted once the DC samples that reached sync2 all disagree with it
  logic [W-1:0]    hist [$];
  logic [W-1:0]    m_stable;
  logic [NBTN-1:0] m_prev_btn, m_press, m_evt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      repeat (DC + 1) hist.push_back('0);
      m_stable   = '0;
      m_prev_btn = '0;
      m_press    = '0;
      m_evt      = '0;
    end else begin
      logic [W-1:0]    nxt;
      logic [NBTN-1:0] pulse;
      logic            agree;
      nxt = m_stable;
      for (int b = 0; b < W; b++) begin
        agree = 1'b1;
        for (int j = 0; j < DC; j++) if (hist[j][b] == m_stable[b]) agree = 1'b0;
        if (agree) nxt[b] = ~m_stable[b];
      end
      pulse      = m_stable[W-1:NSW] & ~m_prev_btn;
      m_evt      = EVT_ON ? (pulse | (m_evt & ~io.i_evt_clr)) : '0;
      m_press    = pulse;
      m_prev_btn = m_stable[W-1:NSW];
      m_stable   = nxt;
      hist.push_back({~io.i_btn, io.i_sw});
      void'(hist.pop_front());
    end
  end
  function automatic logic [71:0] expv();
    return {32'(m_stable[NSW-1:0]), 16'(m_evt), 16'(m_stable[W-1:NSW]), m_press, m_evt};
  endfunction
  task automatic idle(input logic [NSW-1:0] sw, input logic [NBTN-1:0] btn, input int n);
    io.i_sw = sw;
    io.i_btn = btn;
    io.i_evt_clr = '1;
    repeat (n) @(negedge clk);
    io.i_evt_clr = '0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    io.i_sw = 18'h3FFFF;
    io.i_btn = 4'h0;
    io.i_evt_clr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (got !== 72'h0) begin fails++; $display("FAIL reset_hold: got %h want 0", got); end
    rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL reset_model e=%0d: got %h want %h", e, got, expv()); end
      if (e == 4) begin
        checks++;
        if ({io.o_io_sw, io.o_io_btn} !== 64'h0) begin fails++; $display("FAIL reset_early: sw %h btn %h want 0", io.o_io_sw, io.o_io_btn); end
      end
      if (e == 5) begin
        checks++;
        if (io.o_io_sw !== 32'h3FFFF || io.o_io_btn !== 32'hF) begin fails++; $display("FAIL reset_accept: sw %h btn %h want 3ffff/f", io.o_io_sw, io.o_io_btn); end
      end
      if (e == 6) begin
        checks++;
        if (io.o_btn_press !== 4'hF) begin fails++; $display("FAIL reset_press: got %b want 1111", io.o_btn_press); end
      end
    end
  endtask
  task automatic test_switch();
    idle('0, 4'hF, 12);
    io.i_sw = 18'h8;
    for (int e = 0; e < 7; e++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL switch_model e=%0d: got %h want %h", e, got, expv()); end
      if (e == 4) begin
        checks++;
        if (io.o_io_sw !== 32'h0) begin fails++; $display("FAIL switch_early: got %h want 0", io.o_io_sw); end
      end
      if (e == 5) begin
        checks++;
        if (io.o_io_sw !== 32'h8) begin fails++; $display("FAIL switch_accept: got %h want 8", io.o_io_sw); end
      end
    end
  endtask
  task automatic test_glitch();
    idle('0, 4'hF, 12);
    io.i_btn = 4'hE;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL glitch_model i=%0d: got %h want %h", i, got, expv()); end
      checks++;
      if (io.o_io_btn !== 32'h0 || io.o_btn_press !== 4'h0) begin fails++; $display("FAIL glitch_reject i=%0d: btn %h press %b want 0", i, io.o_io_btn, io.o_btn_press); end
      if (i == 2) io.i_btn = 4'hF;
    end
  endtask
  task automatic test_press();
    int pulses = 0;
    idle('0, 4'hF, 12);
    io.i_btn = 4'hD;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL press_model e=%0d: got %h want %h", e, got, expv()); end
      if (io.o_btn_press !== 4'h0) pulses++;
      if (e == 4) begin
        checks++;
        if (io.o_io_btn[1] !== 1'b0) begin fails++; $display("FAIL press_early: got %b want 0", io.o_io_btn[1]); end
      end
      if (e == 5) begin
        checks++;
        if (io.o_io_btn[1] !== 1'b1) begin fails++; $display("FAIL press_level: got %b want 1", io.o_io_btn[1]); end
      end
      if (e == 6) begin
        checks++;
        if (io.o_btn_press !== 4'b0010) begin fails++; $display("FAIL press_pulse: got %b want 0010", io.o_btn_press); end
      end
      if (e == 11) io.i_btn = 4'hF;
    end
    checks++;
    if (pulses != 1 || io.o_io_btn[1] !== 1'b0) begin fails++; $display("FAIL press_count: pulses %0d level %b want 1/0", pulses, io.o_io_btn[1]); end
  endtask
  task automatic test_evt();
    logic [NBTN-1:0] want;
    want = EVT_ON ? 4'b0100 : 4'b0000;
    idle('0, 4'hF, 12);
    io.i_btn = 4'hB;
    for (int e = 0; e < 37; e++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL evt_model e=%0d: got %h want %h", e, got, expv()); end
      if (e == 20 || e == 29) begin
        checks++;
        if (io.o_btn_evt !== want || io.o_io_btn[18] !== want[2]) begin fails++; $display("FAIL evt_set e=%0d: evt %b mirror %b want %b", e, io.o_btn_evt, io.o_io_btn[18], want); end
      end
      if (e == 21 || e == 30) begin
        checks++;
        if (io.o_btn_evt !== 4'h0 || io.o_io_btn[18] !== 1'b0) begin fails++; $display("FAIL evt_clear e=%0d: evt %b mirror %b want 0", e, io.o_btn_evt, io.o_io_btn[18]); end
      end
      if (e == 29) begin
        checks++;
        if (io.o_btn_press !== 4'b0100) begin fails++; $display("FAIL evt_repress: got %b want 0100", io.o_btn_press); end
      end
      if (e == 7 || e == 27) io.i_btn = 4'hF;
      if (e == 20) io.i_evt_clr = 4'b0100;
      if (e == 22) io.i_btn = 4'hB;
    end
    io.i_evt_clr = '0;
  endtask
  task automatic test_reset_mid();
    int pulses = 0;
    idle(18'h155, 4'hF, 12);
    io.i_btn = 4'h7;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== 72'h0) begin fails++; $display("FAIL midreset_clear: got %h want 0", got); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 11; e++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL midreset_model e=%0d: got %h want %h", e, got, expv()); end
      if (io.o_btn_press !== 4'h0) pulses++;
      if (e == 4) begin
        checks++;
        if (io.o_io_btn[3] !== 1'b0) begin fails++; $display("FAIL midreset_early: got %b want 0", io.o_io_btn[3]); end
      end
      if (e == 5) begin
        checks++;
        if (io.o_io_btn[3] !== 1'b1 || io.o_io_sw !== 32'h155) begin fails++; $display("FAIL midreset_accept: btn3 %b sw %h want 1/155", io.o_io_btn[3], io.o_io_sw); end
      end
      if (e == 6) begin
        checks++;
        if (io.o_btn_press !== 4'b1000) begin fails++; $display("FAIL midreset_pulse: got %b want 1000", io.o_btn_press); end
      end
    end
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL midreset_count: got %0d pulses want 1", pulses); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (got !== expv()) begin fails++; $display("FAIL random_model i=%0d: got %h want %h", i, got, expv()); end
      if ($urandom_range(0, 7) == 0) io.i_sw = NSW'($urandom);
      if ($urandom_range(0, 5) == 0) io.i_btn = NBTN'($urandom);
      io.i_evt_clr = ($urandom_range(0, 3) == 0) ? NBTN'($urandom) : '0;
    end
  endtask
  initial begin
    test_reset();
    test_switch();
    test_glitch();
    test_press();
    test_evt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
